fos_tdm_sched: RTL and testbench

FOS_TDM_SCHED -- requirements
Module: fos_tdm_sched

---
 rtl/fos_tdm_sched.sv | 155 +++++++++++++++
 tb/tb_fos_tdm_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fos_tdm_sched.sv
// Time-division-multiplexed first-order section: y = x1 + b1*x2 - a1*yp per channel,
// sharing one external multiplier. Define FOS_TDM_SCHED_SAT_EN to saturate the result.
module fos_tdm_sched #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] in_ch,
  input  logic [31:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [31:0]     out_data,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic            cfg_sel,
  input  logic [31:0]     cfg_data,
  output logic [31:0]     mul_x,
  output logic [31:0]     mul_c,
  input  logic [31:0]     mul_p,
  output logic [1:0]      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready/out_valid depend only on the FSM state, never on the partner's valid/ready.

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_B = 2'd1, MUL_A = 2'd2, OUT = 2'd3} state_t;

  state_t state, state_nxt;

  logic [CH_W-1:0] ch_q;
  logic [31:0]     x_q;
  logic [31:0]     b1_snap;
  logic [31:0]     a1_snap;
  logic [31:0]     pb_q;
  logic [31:0]     y_q;
  logic [31:0]     sum_res;

  logic [31:0] x1_mem [NUM_CH];
  logic [31:0] x2_mem [NUM_CH];
  logic [31:0] yp_mem [NUM_CH];
  logic [31:0] b1_mem [NUM_CH];
  logic [31:0] a1_mem [NUM_CH];

  assign dbg_state = state;
  assign out_ch    = ch_q;
  assign out_data  = y_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MUL_B;
      MUL_B:   state_nxt = MUL_A;
      MUL_A:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, whatever the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_x     = 32'd0;
    mul_c     = 32'd0;
    if (!reset) begin
      case (state)
        IDLE:  in_ready = 1'b1;
        MUL_B: begin
          mul_x = x2_mem[ch_q];
          mul_c = b1_snap;
        end
        MUL_A: begin
          mul_x = yp_mem[ch_q];
          mul_c = a1_snap;
        end
        OUT:   out_valid = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FOS_TDM_SCHED_SAT_EN
  logic [33:0] sum_w;
  always_comb begin
    sum_w = {{2{x1_mem[ch_q][31]}}, x1_mem[ch_q]} + {{2{pb_q[31]}}, pb_q}
          - {{2{mul_p[31]}}, mul_p};
    // Three 32-bit terms fit in 34 bits; overflow shows as bits 33..31 disagreeing.
    if (sum_w[33] && (sum_w[32:31] != 2'b11))
      sum_res = 32'h8000_0000;
    else if (!sum_w[33] && (sum_w[32:31] != 2'b00))
      sum_res = 32'h7FFF_FFFF;
    else
      sum_res = sum_w[31:0];
  end
`else
  assign sum_res = x1_mem[ch_q] + pb_q - mul_p;
`endif

  // Datapath and per-channel state
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q    <= '0;
      x_q     <= 32'd0;
      b1_snap <= 32'd0;
      a1_snap <= 32'd0;
      pb_q    <= 32'd0;
      y_q     <= 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
        x1_mem[i] <= 32'd0;
        x2_mem[i] <= 32'd0;
        yp_mem[i] <= 32'd0;
        b1_mem[i] <= 32'd0;
        a1_mem[i] <= 32'd0;
      end
    end else begin
      // Coefficient writes touch only b1/a1, so they never collide with the OUT update.
      if (cfg_we) begin
        if (cfg_sel) a1_mem[cfg_ch] <= cfg_data;
        else         b1_mem[cfg_ch] <= cfg_data;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            ch_q    <= in_ch;
            x_q     <= in_data;
            b1_snap <= b1_mem[in_ch];
            a1_snap <= a1_mem[in_ch];
          end
        end
        MUL_B: pb_q <= mul_p;
        MUL_A: y_q  <= sum_res;
        OUT: begin
          if (out_ready) begin
            x2_mem[ch_q] <= x1_mem[ch_q];
            x1_mem[ch_q] <= x_q;
            yp_mem[ch_q] <= y_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fos_tdm_sched.sv
// Directed bench for fos_tdm_sched: table of per-sample vectors plus hand sequences
// for reset-in-flight and saturation/wrap corners.
module tb_fos_tdm_sched;

  localparam int CH_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic [31:0]     in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [31:0]     out_data;
  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic            cfg_sel;
  logic [31:0]     cfg_data;
  logic [31:0]     mul_x;
  logic [31:0]     mul_c;
  logic [31:0]     mul_p;
  logic [1:0]      dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [31:0]     x;
    logic [31:0]     exp;
    int              stall;
    string           name;
  } vec_t;

  vec_t vecs[$];

  // Clock / reset block
  always #5 clk = ~clk;

  // Shared multiplier model: low 32 bits of the product.
  assign mul_p = mul_x * mul_c;

  fos_tdm_sched #(.NUM_CH(4), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .mul_x(mul_x), .mul_c(mul_c), .mul_p(mul_p), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_ch", {30'd0, out_ch}, 32'd0);
    check("rst_mul_x", mul_x, 32'd0);
    check("rst_mul_c", mul_c, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic sel, input logic [31:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_sel  = sel;
    cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  // Drive one sample; check latency, result, and hold behaviour while stalled.
  task automatic send(input logic [CH_W-1:0] ch, input logic [31:0] x,
                      input logic [31:0] exp, input int stall, input string name);
    int lat;
    logic [31:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    out_ready = (stall == 0);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = x;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 8);
    check({name, "_latency"}, lat, 32'd3);
    e = exp_q.pop_front();
    check({name, "_data"}, out_data, e);
    check({name, "_ch"}, {30'd0, out_ch}, {30'd0, ch});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, "_hold_data"}, out_data, e);
      check({name, "_hold_ch"}, {30'd0, out_ch}, {30'd0, ch});
      check({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({name, "_hold_mul_x"}, mul_x, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_done"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_sel   = 1'b0;
    cfg_data  = 32'd0;

    do_reset();

    cfg_write(2'd1, 1'b0, 32'd2);
    cfg_write(2'd1, 1'b1, 32'd1);
    cfg_write(2'd2, 1'b0, 32'd3);
    cfg_write(2'd2, 1'b1, 32'd2);
    cfg_write(2'd3, 1'b0, 32'hFFFF_FFFF);
    cfg_write(2'd3, 1'b1, 32'd4);

    vecs.push_back('{2'd0, 32'd5,   32'd0,          0, "ch0_s0"});
    vecs.push_back('{2'd0, 32'd7,   32'd5,          0, "ch0_s1"});
    vecs.push_back('{2'd1, 32'd10,  32'd0,          0, "ch1_s0"});
    vecs.push_back('{2'd1, 32'd20,  32'd10,         0, "ch1_s1"});
    vecs.push_back('{2'd1, 32'd30,  32'd30,         0, "ch1_s2"});
    vecs.push_back('{2'd2, 32'd1,   32'd0,          0, "ch2_s0"});
    vecs.push_back('{2'd3, 32'd100, 32'd0,          0, "ch3_s0"});
    vecs.push_back('{2'd2, 32'd2,   32'd1,          0, "ch2_s1"});
    vecs.push_back('{2'd3, 32'd200, 32'd100,        0, "ch3_s1"});
    vecs.push_back('{2'd2, 32'd3,   32'd3,          0, "ch2_s2"});
    vecs.push_back('{2'd3, 32'd300, 32'hFFFF_FED4, 0, "ch3_s2"});
    vecs.push_back('{2'd2, 32'd4,   32'd3,          0, "ch2_s3"});
    vecs.push_back('{2'd1, 32'd40,  32'd40,         6, "ch1_stall"});
    vecs.push_back('{2'd1, 32'd0,   32'd60,         0, "ch1_after"});

    for (int i = 0; i < vecs.size(); i++)
      send(vecs[i].ch, vecs[i].x, vecs[i].exp, vecs[i].stall, vecs[i].name);

    // Saturation / wrap corner on a freshly reset channel 0.
    do_reset();
    cfg_write(2'd0, 1'b0, 32'd1);
    send(2'd0, 32'h7FFF_FFFF, 32'd0, 0, "sat_s0");
    send(2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, "sat_s1");
`ifdef FOS_TDM_SCHED_SAT_EN
    send(2'd0, 32'd0, 32'h7FFF_FFFF, 0, "sat_s2");
`else
    send(2'd0, 32'd0, 32'hFFFF_FFFE, 0, "wrap_s2");
`endif

    // Reset while a sample is in MUL_A aborts it and clears channel history.
    do_reset();
    cfg_write(2'd1, 1'b0, 32'd2);
    send(2'd1, 32'd10, 32'd0, 0, "abort_pre");
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = 2'd1;
    in_data  = 32'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_state_mul_a", {30'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    #1;
    check("abort_mul_x", mul_x, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready_rst", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid_after", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready_after", {31'd0, in_ready}, 32'd1);
    send(2'd1, 32'd20, 32'd0, 0, "abort_resend");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
